yolo_acc_top_hls_axis_block_detector: RTL and testbench

//  Per-channel AXI-Stream stall detector; drives the axis_block_sigs vector consumed by the

---
 rtl/yolo_acc_dbg_pkg.sv | 15 +
 rtl/yolo_acc_top_hls_axis_block_detector_if.sv | 27 ++
 rtl/yolo_acc_top_hls_axis_stall_cnt.sv | 34 +++
 rtl/yolo_acc_top_hls_axis_block_detector.sv | 93 +++++++++
 tb/tb_yolo_acc_top_hls_axis_block_detector.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/yolo_acc_dbg_pkg.sv
// rtl/yolo_acc_dbg_pkg.sv - shared debug-monitor encodings and default sizing
package yolo_acc_dbg_pkg;

  typedef enum logic [1:0] {
    ST_MON  = 2'd0,
    ST_CAP  = 2'd1,
    ST_COOL = 2'd2
  } report_state_e;

  localparam int DBG_NUM_CH = 4;
  localparam int DBG_CNT_W  = 8;
  localparam int DBG_THRESH = 16;
  localparam int DBG_IDX_W  = 2;

endpackage

// File: rtl/yolo_acc_top_hls_axis_block_detector_if.sv
// rtl/yolo_acc_top_hls_axis_block_detector_if.sv - stream-watch and report signals of the stall detector
interface yolo_acc_top_hls_axis_block_detector_if
  import yolo_acc_dbg_pkg::*;
#(
  parameter int NUM_CH = DBG_NUM_CH,
  parameter int IDX_W  = DBG_IDX_W
);
  logic [NUM_CH-1:0] ch_tvalid;
  logic [NUM_CH-1:0] ch_tready;
  logic [NUM_CH-1:0] ch_is_rd;
  logic              inst_idle;
  logic [NUM_CH-1:0] axis_block_sigs;
  logic              any_block;
  logic              first_valid;
  logic [IDX_W-1:0]  first_ch;
  logic              report_ack;

  modport master (
    output ch_tvalid, ch_tready, ch_is_rd, inst_idle, report_ack,
    input  axis_block_sigs, any_block, first_valid, first_ch
  );

  modport slave (
    input  ch_tvalid, ch_tready, ch_is_rd, inst_idle, report_ack,
    output axis_block_sigs, any_block, first_valid, first_ch
  );
endinterface

// File: rtl/yolo_acc_top_hls_axis_stall_cnt.sv
// rtl/yolo_acc_top_hls_axis_stall_cnt.sv - single-channel wait decode and saturating stall counter
module yolo_acc_top_hls_axis_stall_cnt
  import yolo_acc_dbg_pkg::*;
#(
  parameter int CNT_W  = DBG_CNT_W,
  parameter int THRESH = DBG_THRESH
) (
  input  logic clock,
  input  logic reset,
  input  logic tvalid,
  input  logic tready,
  input  logic is_rd,
  input  logic inst_idle,
  output logic blocked
);
  logic             waiting;
  logic [CNT_W-1:0] cnt_q;

  // Reader waits on an empty source; writer waits on a full sink.
  assign waiting = is_rd ? (tready & ~tvalid) : (tvalid & ~tready);

  always_ff @(posedge clock) begin
    if (reset || inst_idle) begin
      cnt_q <= '0;
    end else if (!waiting) begin
      cnt_q <= '0;
    end else if (cnt_q < CNT_W'(THRESH)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign blocked = (cnt_q == CNT_W'(THRESH));

endmodule

// File: rtl/yolo_acc_top_hls_axis_block_detector.sv
// rtl/yolo_acc_top_hls_axis_block_detector.sv - per-channel stall flags plus first-blocker capture FSM
module yolo_acc_top_hls_axis_block_detector
  import yolo_acc_dbg_pkg::*;
#(
  parameter int NUM_CH = DBG_NUM_CH,
  parameter int CNT_W  = DBG_CNT_W,
  parameter int THRESH = DBG_THRESH,
  parameter int IDX_W  = DBG_IDX_W
) (
  input logic clock,
  input logic reset,
  yolo_acc_top_hls_axis_block_detector_if.slave dbg
);
  logic [NUM_CH-1:0] blk;
  logic              any_blk;
  logic [IDX_W-1:0]  lowest_idx;

  report_state_e     state_q, state_d;
  logic [IDX_W-1:0]  first_ch_q, first_ch_d;
  logic              first_valid_q, first_valid_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    yolo_acc_top_hls_axis_stall_cnt #(
      .CNT_W  (CNT_W),
      .THRESH (THRESH)
    ) u_stall_cnt (
      .clock     (clock),
      .reset     (reset),
      .tvalid    (dbg.ch_tvalid[g]),
      .tready    (dbg.ch_tready[g]),
      .is_rd     (dbg.ch_is_rd[g]),
      .inst_idle (dbg.inst_idle),
      .blocked   (blk[g])
    );
  end

  assign any_blk = |blk;

  // Scan from the top down so the lowest blocked index wins.
  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (blk[i]) lowest_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_MON;
      first_ch_q    <= '0;
      first_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      first_ch_q    <= first_ch_d;
      first_valid_q <= first_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    first_ch_d    = first_ch_q;
    first_valid_d = first_valid_q;
    case (state_q)
      ST_MON: begin
        if (any_blk) begin
          state_d       = ST_CAP;
          first_ch_d    = lowest_idx;
          first_valid_d = 1'b1;
        end
      end
      ST_CAP: begin
        if (dbg.report_ack) begin
          state_d       = ST_COOL;
          first_valid_d = 1'b0;
        end
      end
      ST_COOL: begin
        // Stay quiet until every channel has drained, so one stall is reported once.
        if (!any_blk) state_d = ST_MON;
      end
      default: begin
        state_d       = ST_MON;
        first_valid_d = 1'b0;
      end
    endcase
  end

  assign dbg.axis_block_sigs = blk;
  assign dbg.any_block       = any_blk;
  assign dbg.first_valid     = first_valid_q;
  assign dbg.first_ch        = first_ch_q;

endmodule

// File: tb/tb_yolo_acc_top_hls_axis_block_detector.sv
// tb/tb_yolo_acc_top_hls_axis_block_detector.sv - self-checking bench for the stall detector
module tb_yolo_acc_top_hls_axis_block_detector;
  localparam int NCH = 4;
  localparam int TH  = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;

  yolo_acc_top_hls_axis_block_detector_if #(.NUM_CH(NCH), .IDX_W(2)) dbg ();

  yolo_acc_top_hls_axis_block_detector #(
    .NUM_CH (NCH),
    .CNT_W  (8),
    .THRESH (TH),
    .IDX_W  (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .dbg   (dbg)
  );

  always #5 clock = ~clock;

  int         tests_run = 0;
  int         failures  = 0;
  int         run_len[NCH];
  logic [3:0] exp_sigs = '0;
  logic       exp_any  = 1'b0;
  logic       exp_fv   = 1'b0;
  logic [1:0] exp_fc   = '0;
  bit         held     = 1'b0;
  bit         cooling  = 1'b0;

  function automatic logic [1:0] lowest_of(input logic [3:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic bit is_waiting(input int i);
    if (dbg.ch_is_rd[i]) return dbg.ch_tready[i] && !dbg.ch_tvalid[i];
    return dbg.ch_tvalid[i] && !dbg.ch_tready[i];
  endfunction

  // One clock edge: advance the behavioural model with the inputs that were stable before it.
  task automatic tick();
    logic [3:0] prev;
    @(posedge clock);
    prev = exp_sigs;
    if (reset) begin
      held = 0; cooling = 0; exp_fc = '0;
      for (int i = 0; i < NCH; i++) run_len[i] = 0;
    end else begin
      if (!held && !cooling) begin
        if (|prev) begin held = 1; exp_fc = lowest_of(prev); end
      end else if (held) begin
        if (dbg.report_ack) begin held = 0; cooling = 1; end
      end else if (!(|prev)) begin
        cooling = 0;
      end
      for (int i = 0; i < NCH; i++) begin
        if (dbg.inst_idle || !is_waiting(i)) run_len[i] = 0;
        else run_len[i] = run_len[i] + 1;
      end
    end
    for (int i = 0; i < NCH; i++) exp_sigs[i] = (run_len[i] >= TH);
    exp_any = |exp_sigs;
    exp_fv  = held;
    #1;
  endtask

  task automatic quiet();
    dbg.ch_tvalid  = '0;
    dbg.ch_tready  = '0;
    dbg.inst_idle  = 1'b0;
    dbg.report_ack = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    dbg.ch_is_rd = 4'b0001;
    do_reset();
    tests_run++;
    if ({dbg.axis_block_sigs, dbg.any_block, dbg.first_valid, dbg.first_ch} !== 8'h00) begin
      failures++;
      $display("FAIL reset_state got sigs=%b any=%b fv=%b fc=%0d want all zero",
               dbg.axis_block_sigs, dbg.any_block, dbg.first_valid, dbg.first_ch);
    end
  endtask

  task automatic test_rd_starve();
    dbg.ch_is_rd = 4'b0001;
    do_reset();
    dbg.ch_tready[0] = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      tests_run++;
      if ({dbg.axis_block_sigs, dbg.any_block, dbg.first_valid, dbg.first_ch} !== {exp_sigs, exp_any, exp_fv, exp_fc}) begin
        failures++;
        $display("FAIL rd_starve cyc=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", k, dbg.axis_block_sigs,
                 dbg.any_block, dbg.first_valid, dbg.first_ch, exp_sigs, exp_any, exp_fv, exp_fc);
      end
      if (k == 15 || k == 16) begin
        tests_run++;
        if (dbg.axis_block_sigs[0] !== (k == 16) || dbg.first_valid !== 1'b0) begin
          failures++;
          $display("FAIL rd_edge cyc=%0d got sig0=%b fv=%b want sig0=%b fv=0", k,
                   dbg.axis_block_sigs[0], dbg.first_valid, (k == 16));
        end
      end
    end
    tests_run++;
    if (dbg.first_valid !== 1'b1 || dbg.first_ch !== 2'd0) begin
      failures++;
      $display("FAIL rd_capture got fv=%b fc=%0d want fv=1 fc=0", dbg.first_valid, dbg.first_ch);
    end
    dbg.report_ack = 1'b1;
    tick();
    quiet();
    tick();
    tick();
    // 15 waiting cycles, a transfer, then 10 more: never reaches the threshold.
    dbg.ch_tready[0] = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      dbg.ch_tvalid[0] = (k == 16);
      tick();
      tests_run++;
      if ({dbg.axis_block_sigs, dbg.any_block, dbg.first_valid, dbg.first_ch} !== {exp_sigs, exp_any, exp_fv, exp_fc}
          || dbg.axis_block_sigs[0] !== 1'b0) begin
        failures++;
        $display("FAIL rd_pulse cyc=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", k, dbg.axis_block_sigs,
                 dbg.any_block, dbg.first_valid, dbg.first_ch, exp_sigs, exp_any, exp_fv, exp_fc);
      end
    end
  endtask

  task automatic test_wr_backpressure();
    dbg.ch_is_rd = 4'b0001;
    do_reset();
    dbg.ch_tvalid[2] = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      dbg.ch_tready[2] = (k == 21);
      tick();
      tests_run++;
      if (dbg.axis_block_sigs[2] !== (k >= 16 && k <= 20) ||
          {dbg.axis_block_sigs, dbg.any_block, dbg.first_valid, dbg.first_ch} !== {exp_sigs, exp_any, exp_fv, exp_fc}) begin
        failures++;
        $display("FAIL wr_bp cyc=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", k, dbg.axis_block_sigs,
                 dbg.any_block, dbg.first_valid, dbg.first_ch, exp_sigs, exp_any, exp_fv, exp_fc);
      end
    end
    quiet();
    for (int k = 0; k < 5; k++) tick();
    tests_run++;
    if (dbg.first_valid !== 1'b1 || dbg.first_ch !== 2'd2) begin
      failures++;
      $display("FAIL wr_hold got fv=%b fc=%0d want fv=1 fc=2", dbg.first_valid, dbg.first_ch);
    end
    dbg.report_ack = 1'b1;
    tick();
    dbg.report_ack = 1'b0;
    tests_run++;
    if (dbg.first_valid !== 1'b0) begin
      failures++;
      $display("FAIL wr_ack got fv=%b want 0", dbg.first_valid);
    end
  endtask

  task automatic test_simultaneous();
    dbg.ch_is_rd = 4'b0001;
    do_reset();
    dbg.ch_tvalid[1] = 1'b1;
    dbg.ch_tvalid[3] = 1'b1;
    for (int k = 0; k < 17; k++) tick();
    tests_run++;
    if (dbg.axis_block_sigs !== 4'b1010 || dbg.first_valid !== 1'b1 || dbg.first_ch !== 2'd1) begin
      failures++;
      $display("FAIL simul_cap got sigs=%b fv=%b fc=%0d want 1010/1/1", dbg.axis_block_sigs,
               dbg.first_valid, dbg.first_ch);
    end
    dbg.ch_tvalid[1] = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    tests_run++;
    if (dbg.axis_block_sigs !== 4'b1000 || dbg.first_valid !== 1'b1 || dbg.first_ch !== 2'd1) begin
      failures++;
      $display("FAIL simul_hold got sigs=%b fv=%b fc=%0d want 1000/1/1", dbg.axis_block_sigs,
               dbg.first_valid, dbg.first_ch);
    end
  endtask

  task automatic test_ack_cool();
    dbg.report_ack = 1'b1;
    tick();
    dbg.report_ack = 1'b0;
    dbg.ch_tready[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      tests_run++;
      if (dbg.first_valid !== 1'b0 ||
          {dbg.axis_block_sigs, dbg.any_block, dbg.first_valid, dbg.first_ch} !== {exp_sigs, exp_any, exp_fv, exp_fc}) begin
        failures++;
        $display("FAIL cool_nocap cyc=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", k, dbg.axis_block_sigs,
                 dbg.any_block, dbg.first_valid, dbg.first_ch, exp_sigs, exp_any, exp_fv, exp_fc);
      end
    end
    quiet();
    tick();
    tick();
    dbg.ch_tready[0] = 1'b1;
    for (int k = 0; k < 17; k++) tick();
    tests_run++;
    if (dbg.first_valid !== 1'b1 || dbg.first_ch !== 2'd0) begin
      failures++;
      $display("FAIL cool_recap got fv=%b fc=%0d want fv=1 fc=0", dbg.first_valid, dbg.first_ch);
    end
  endtask

  task automatic test_idle_restart();
    dbg.ch_is_rd = 4'b0001;
    do_reset();
    dbg.ch_tready[0] = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    dbg.inst_idle = 1'b1;
    tick();
    dbg.inst_idle = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k >= 15) begin
        tests_run++;
        if (dbg.axis_block_sigs[0] !== (k == 16) || exp_sigs[0] !== (k == 16)) begin
          failures++;
          $display("FAIL idle_restart cyc=%0d got sig0=%b want %b", k, dbg.axis_block_sigs[0], (k == 16));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    dbg.ch_is_rd = 4'b0001;
    do_reset();
    dbg.ch_tvalid[1] = 1'b1;
    dbg.ch_tvalid[3] = 1'b1;
    for (int k = 0; k < 18; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if ({dbg.axis_block_sigs, dbg.any_block, dbg.first_valid, dbg.first_ch} !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid got sigs=%b any=%b fv=%b fc=%0d want all zero",
               dbg.axis_block_sigs, dbg.any_block, dbg.first_valid, dbg.first_ch);
    end
    quiet();
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      dbg.ch_is_rd = 4'($urandom);
      do_reset();
      for (int k = 0; k < 300; k++) begin
        for (int i = 0; i < NCH; i++) begin
          if ($urandom_range(0, 11) == 0) begin
            dbg.ch_tvalid[i] = 1'($urandom);
            dbg.ch_tready[i] = 1'($urandom);
          end
        end
        dbg.report_ack = ($urandom_range(0, 7) == 0);
        dbg.inst_idle  = ($urandom_range(0, 63) == 0);
        reset          = ($urandom_range(0, 299) == 0);
        tick();
        tests_run++;
        if ({dbg.axis_block_sigs, dbg.any_block, dbg.first_valid, dbg.first_ch} !== {exp_sigs, exp_any, exp_fv, exp_fc}) begin
          failures++;
          $display("FAIL random r=%0d cyc=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", r, k, dbg.axis_block_sigs,
                   dbg.any_block, dbg.first_valid, dbg.first_ch, exp_sigs, exp_any, exp_fv, exp_fc);
        end
      end
      reset = 1'b0;
    end
  endtask

  initial begin
    dbg.ch_is_rd = 4'b0001;
    quiet();
    for (int i = 0; i < NCH; i++) run_len[i] = 0;
    test_reset();
    test_rd_starve();
    test_wr_backpressure();
    test_simultaneous();
    test_ack_cool();
    test_idle_restart();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
